bist_sequencer: RTL and testbench

- Multi-pattern BIST session sequencer for the arbiter BIST wrapper.
- Drives the functional-input mux select, the module init/reset pulse, the scan-enable toggle and MISR capture gating.
- Runs NUM_PATTERNS scan-load / capture iterations, then a final unload, then compares the MISR signature against the golden value.
- Sits between the top-level bist_start/bist_end pins and the LFSR, scan chain and MISR.

---
 rtl/bist_pkg.sv | 22 ++
 rtl/bist_counter.sv | 30 +++
 rtl/bist_sequencer.sv | 114 +++++++++++
 tb/tb_bist_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST session sequencer and its counters.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_UNLOAD  = 3'd4,
    ST_COMPARE = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic [7:0]  SIGNATURE_VALID_8  = 8'hF9;
  localparam logic [15:0] SIGNATURE_VALID_16 = 16'hB3F9;

  // Bits needed to hold the value n itself (not just 0..n-1).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bist_counter.sv
// Loadable up-counter with a terminal-count flag; load has priority over enable.
module bist_counter #(
  parameter int           W        = 5,
  parameter logic [W-1:0] TERMINAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en) begin
      count_reg <= count_reg + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == TERMINAL);

endmodule

// File: rtl/bist_sequencer.sv
// BIST session sequencer: init pulse, SCAN_LEN-cycle loads with single captures,
// final unload, then a one-cycle MISR signature compare held in DONE.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int                   SCAN_LEN        = 16,
  parameter int                   NUM_PATTERNS    = 64,
  parameter int                   MISR_BITS       = 8,
  parameter logic [MISR_BITS-1:0] SIGNATURE_VALID = MISR_BITS'(SIGNATURE_VALID_8),
  parameter int                   SHIFT_W         = cnt_width(SCAN_LEN),
  parameter int                   PAT_W           = cnt_width(NUM_PATTERNS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [MISR_BITS-1:0] signature_in,
  output logic                 init,
  output logic                 running,
  output logic                 scan_en,
  output logic                 capture,
  output logic [PAT_W-1:0]     pattern_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail
);

  state_t state_reg, state_next;
  logic   pass_reg, fail_reg;
  logic   shifting, shift_last, pat_last;
  logic   shift_load, pat_load;
  logic [SHIFT_W-1:0] shift_cnt_unused;

  assign shifting   = (state_reg == ST_LOAD) || (state_reg == ST_UNLOAD);
  assign shift_load = abort || (state_reg == ST_INIT) || (shifting && shift_last);
  assign pat_load   = abort || (state_reg == ST_INIT);

  // Only the terminal flag of the shift counter steers the FSM.
  bist_counter #(
    .W        (SHIFT_W),
    .TERMINAL (SHIFT_W'(SCAN_LEN - 1))
  ) u_shift_cnt (
    .clock      (clock),
    .reset      (reset),
    .load       (shift_load),
    .load_value ('0),
    .en         (shifting),
    .count      (shift_cnt_unused),
    .tc         (shift_last)
  );

  bist_counter #(
    .W        (PAT_W),
    .TERMINAL (PAT_W'(NUM_PATTERNS - 1))
  ) u_pat_cnt (
    .clock      (clock),
    .reset      (reset),
    .load       (pat_load),
    .load_value ('0),
    .en         (state_reg == ST_CAPTURE),
    .count      (pattern_cnt),
    .tc         (pat_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:    if (start) state_next = ST_INIT;
        ST_INIT:    state_next = ST_LOAD;
        ST_LOAD:    if (shift_last) state_next = ST_CAPTURE;
        ST_CAPTURE: state_next = pat_last ? ST_UNLOAD : ST_LOAD;
        ST_UNLOAD:  if (shift_last) state_next = ST_COMPARE;
        ST_COMPARE: state_next = ST_DONE;
        ST_DONE:    if (start) state_next = ST_INIT;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || abort || (state_reg == ST_INIT)) begin
      pass_reg <= 1'b0;
      fail_reg <= 1'b0;
    end else if (state_reg == ST_COMPARE) begin
      pass_reg <= (signature_in == SIGNATURE_VALID);
      fail_reg <= (signature_in != SIGNATURE_VALID);
    end
  end

  // Verdict is gated by DONE so it never leaks into the INIT cycle of a re-run.
  always_comb begin
    init    = (state_reg == ST_INIT);
    running = shifting || (state_reg == ST_CAPTURE);
    scan_en = shifting;
    capture = (state_reg == ST_CAPTURE);
    busy    = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    done    = (state_reg == ST_DONE);
    pass    = done && pass_reg;
    fail    = done && fail_reg;
  end

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench: small-parameter instance for the timing tables, default instance for latency.
module tb_bist_sequencer;

  logic       clock;
  logic       reset;
  logic       start, abort;
  logic [7:0] signature_in;
  logic       init, running, scan_en, capture, busy, done, pass, fail;
  logic [1:0] pattern_cnt;

  logic       start_d, abort_d;
  logic [7:0] signature_d;
  logic       init_d, running_d, scan_en_d, capture_d, busy_d, done_d, pass_d, fail_d;
  logic [6:0] pattern_cnt_d;

  int checks = 0;
  int errors = 0;

  bist_sequencer #(
    .SCAN_LEN (4), .NUM_PATTERNS (3), .MISR_BITS (8),
    .SIGNATURE_VALID (8'hF9), .SHIFT_W (3), .PAT_W (2)
  ) dut (
    .clock (clock), .reset (reset), .start (start), .abort (abort),
    .signature_in (signature_in), .init (init), .running (running),
    .scan_en (scan_en), .capture (capture), .pattern_cnt (pattern_cnt),
    .busy (busy), .done (done), .pass (pass), .fail (fail)
  );

  bist_sequencer dut_def (
    .clock (clock), .reset (reset), .start (start_d), .abort (abort_d),
    .signature_in (signature_d), .init (init_d), .running (running_d),
    .scan_en (scan_en_d), .capture (capture_d), .pattern_cnt (pattern_cnt_d),
    .busy (busy_d), .done (done_d), .pass (pass_d), .fail (fail_d)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge; returns positioned in cycle 1 of the session.
  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int c;
    int busy_cnt;
    start = 0; abort = 0; signature_in = 8'hF9;
    start_d = 0; abort_d = 0; signature_d = 8'hF9;
    reset = 1'b1;
    tick();
    tick();
    check("reset_init",    {31'd0, init},    0);
    check("reset_running", {31'd0, running}, 0);
    check("reset_scan_en", {31'd0, scan_en}, 0);
    check("reset_capture", {31'd0, capture}, 0);
    check("reset_busy",    {31'd0, busy},    0);
    check("reset_done",    {31'd0, done},    0);
    check("reset_pass",    {31'd0, pass},    0);
    check("reset_fail",    {31'd0, fail},    0);
    check("reset_pcnt",    {30'd0, pattern_cnt}, 0);
    reset = 1'b0;
    tick();

    // Nominal run with cycle-by-cycle strobe table, then re-run from DONE.
    launch();
    for (c = 1; c <= 29; c++) begin
      check($sformatf("nom_init_c%0d", c), {31'd0, init}, {31'd0, c == 1});
      check($sformatf("nom_scan_c%0d", c), {31'd0, scan_en},
            {31'd0, (c >= 2 && c <= 5) || (c >= 7 && c <= 10) || (c >= 12 && c <= 15) || (c >= 17 && c <= 20)});
      check($sformatf("nom_cap_c%0d", c), {31'd0, capture}, {31'd0, c == 6 || c == 11 || c == 16});
      check($sformatf("nom_run_c%0d", c), {31'd0, running}, {31'd0, c >= 2 && c <= 20});
      check($sformatf("nom_done_c%0d", c), {31'd0, done}, {31'd0, c >= 22});
      if (c == 7)  check("nom_pcnt_c7", {30'd0, pattern_cnt}, 1);
      if (c >= 22) begin
        check($sformatf("nom_pass_c%0d", c), {31'd0, pass}, 1);
        check($sformatf("nom_fail_c%0d", c), {31'd0, fail}, 0);
        check($sformatf("nom_pcnt_c%0d", c), {30'd0, pattern_cnt}, 3);
        check($sformatf("nom_busy_c%0d", c), {31'd0, busy}, 0);
      end
      tick();
    end
    // Now in cycle 30: hold start through the re-run session.
    start = 1'b1;
    for (c = 31; c <= 52; c++) begin
      tick();
      if (c == 51) start = 1'b0;
      if (c == 31) begin
        check("rerun_init_c31", {31'd0, init}, 1);
        check("rerun_done_c31", {31'd0, done}, 0);
        check("rerun_pass_c31", {31'd0, pass}, 0);
      end
      if (c == 51) check("rerun_done_c51", {31'd0, done}, 0);
    end
    check("rerun_done_c52", {31'd0, done}, 1);
    check("rerun_pass_c52", {31'd0, pass}, 1);
    check("rerun_pcnt_c52", {30'd0, pattern_cnt}, 3);
    tick();
    check("rerun_hold_c53", {31'd0, done}, 1);

    // Bad signature, then signature change after compare, then abort from DONE.
    do_reset();
    signature_in = 8'hF8;
    launch();
    for (c = 1; c < 21; c++) tick();
    check("bad_done_c21", {31'd0, done}, 0);
    tick();
    check("bad_done_c22", {31'd0, done}, 1);
    check("bad_pass_c22", {31'd0, pass}, 0);
    check("bad_fail_c22", {31'd0, fail}, 1);
    check("bad_pcnt_c22", {30'd0, pattern_cnt}, 3);
    signature_in = 8'hF9;
    tick();
    check("bad_fail_held", {31'd0, fail}, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done_state", {31'd0, done}, 0);
    check("abort_done_fail",  {31'd0, fail}, 0);
    check("abort_done_pcnt",  {30'd0, pattern_cnt}, 0);

    // Abort during LOAD in cycle 8.
    do_reset();
    launch();
    for (c = 1; c < 8; c++) tick();
    abort = 1'b1;
    #1;
    check("abort_c8_scan", {31'd0, scan_en}, 1);
    check("abort_c8_pcnt", {30'd0, pattern_cnt}, 1);
    tick();
    abort = 1'b0;
    check("abort_c9_busy", {31'd0, busy}, 0);
    check("abort_c9_run",  {31'd0, running}, 0);
    check("abort_c9_scan", {31'd0, scan_en}, 0);
    check("abort_c9_pcnt", {30'd0, pattern_cnt}, 0);
    check("abort_c9_done", {31'd0, done}, 0);

    // start and abort together in IDLE stay in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("both_idle_init", {31'd0, init}, 0);
    check("both_idle_busy", {31'd0, busy}, 0);
    tick();
    check("both_idle_busy2", {31'd0, busy}, 0);

    // Reset during UNLOAD at cycle 18.
    do_reset();
    launch();
    for (c = 1; c < 18; c++) tick();
    check("rst_c18_scan", {31'd0, scan_en}, 1);
    reset = 1'b1;
    tick();
    check("rst_c19_run",  {31'd0, running}, 0);
    check("rst_c19_scan", {31'd0, scan_en}, 0);
    check("rst_c19_busy", {31'd0, busy}, 0);
    check("rst_c19_init", {31'd0, init}, 0);
    check("rst_c19_pcnt", {30'd0, pattern_cnt}, 0);
    reset = 1'b0;
    tick();
    check("rst_c20_init", {31'd0, init}, 0);
    check("rst_c20_busy", {31'd0, busy}, 0);

    // Default parameters: latency and busy duration.
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    c = 1;
    busy_cnt = 0;
    while (c <= 2000 && !done_d) begin
      if (busy_d) busy_cnt++;
      tick();
      c++;
    end
    check("def_done_cycle", c, 1107);
    check("def_busy_cycles", busy_cnt, 1106);
    check("def_pass", {31'd0, pass_d}, 1);
    check("def_fail", {31'd0, fail_d}, 0);
    check("def_pcnt", {25'd0, pattern_cnt_d}, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
